// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential arithmetic units: state encoding common to
// the divider and the multiplier FSMs, default operand width and counter sizing.
package seq_restoring_divider_pkg;

    localparam int N_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Iteration counter must hold 0..2N without wrapping.
    function automatic int cnt_width(input int n);
        return $clog2(2 * n + 1);
    endfunction

endpackage

// File: rtl/seq_restoring_divider_datapath.sv
// Restoring-division datapath: dividend/quotient shift register, captured divisor,
// partial remainder, trial subtractor and step counter.
module seq_restoring_divider_datapath
    import seq_restoring_divider_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [2*N-1:0]   a_i,
    input  logic [N-1:0]     b_i,
    output logic [2*N-1:0]   q_step_o,
    output logic [N-1:0]     r_step_o,
    output logic             last_o
);

    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST_CNT = CW'(2 * N - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [2*N-1:0] d_q, d_d, d_step_s;
    logic [N-1:0]   v_q, v_d;
    logic [N:0]     p_q, p_d, p_step_s;
    logic [N:0]     sh_s, t_s;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           qbit_s;

    // One restoring step; P is N+1 bits so a negative trial shows up in t_s[N].
    always_comb begin
        sh_s = {p_q[N-1:0], d_q[2*N-1]};
        t_s  = sh_s - {1'b0, v_q};
        if (t_s[N] == 1'b0) begin
            p_step_s = t_s;
            qbit_s   = 1'b1;
        end else begin
            p_step_s = sh_s;
            qbit_s   = 1'b0;
        end
        d_step_s = {d_q[2*N-2:0], qbit_s};
    end

    // Next-state selection for load / step / hold.
    always_comb begin
        d_d   = d_q;
        v_d   = v_q;
        p_d   = p_q;
        cnt_d = cnt_q;
        if (load_i) begin
            d_d   = a_i;
            v_d   = b_i;
            p_d   = {(N+1){1'b0}};
            cnt_d = {CW{1'b0}};
        end else if (step_i) begin
            d_d   = d_step_s;
            p_d   = p_step_s;
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            d_d   = d_q;
            p_d   = p_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q   <= {(2*N){1'b0}};
            v_q   <= {N{1'b0}};
            p_q   <= {(N+1){1'b0}};
            cnt_q <= {CW{1'b0}};
        end else begin
            d_q   <= d_d;
            v_q   <= v_d;
            p_q   <= p_d;
            cnt_q <= cnt_d;
        end
    end

    assign q_step_o = d_step_s;
    assign r_step_o = p_step_s[N-1:0];
    assign last_o   = (cnt_q == LAST_CNT);

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider, 2N/N -> 2N quotient + N remainder, one quotient bit
// per clock, with the s/Done start-complete handshake shared with the multiplier.
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s,
    input  logic [2*N-1:0]   A,
    input  logic [N-1:0]     B,
    output logic             Busy,
    output logic             Done,
    output logic             DZ,
    output logic [2*N-1:0]   Q,
    output logic [N-1:0]     R
);

    state_e         state_q, state_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           dz_q, dz_d;
    logic [2*N-1:0] q_q, q_d;
    logic [N-1:0]   r_q, r_d;
    logic           load_s, step_s, last_s;
    logic [2*N-1:0] q_step_s;
    logic [N-1:0]   r_step_s;

    seq_restoring_divider_datapath #(.N(N)) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load_s),
        .step_i   (step_s),
        .a_i      (A),
        .b_i      (B),
        .q_step_o (q_step_s),
        .r_step_o (r_step_s),
        .last_o   (last_s)
    );

    // Next-state, datapath controls and registered-output next values.
    always_comb begin
        state_d = state_q;
        load_s  = 1'b0;
        step_s  = 1'b0;
        dz_d    = dz_q;
        q_d     = q_q;
        r_d     = r_q;
        case (state_q)
            ST_IDLE: begin
                if (s) begin
                    if (B != {N{1'b0}}) begin
                        load_s  = 1'b1;
                        dz_d    = 1'b0;
                        state_d = ST_BUSY;
                    end else begin
                        q_d     = {(2*N){1'b1}};
                        r_d     = {N{1'b0}};
                        dz_d    = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                step_s = 1'b1;
                if (last_s) begin
                    q_d     = q_step_s;
                    r_d     = r_step_s;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_BUSY);
        done_d = (state_d == ST_DONE);
    end

    // State and registered Moore outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            q_q     <= {(2*N){1'b0}};
            r_q     <= {N{1'b0}};
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            q_q     <= q_d;
            r_q     <= r_d;
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign DZ   = dz_q;
    assign Q    = q_q;
    assign R    = r_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed cases, exhaustive sweep and
// random operands checked against plain integer division.
module tb_seq_restoring_divider;

    localparam int N = 4;
    typedef logic [2*N-1:0] dvd_t;
    typedef logic [N-1:0]   dvs_t;

    logic clk = 1'b0;
    logic rst, s;
    dvd_t A, Q;
    dvs_t B, R;
    logic Busy, Done, DZ;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_restoring_divider #(.N(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .s    (s),
        .A    (A),
        .B    (B),
        .Busy (Busy),
        .Done (Done),
        .DZ   (DZ),
        .Q    (Q),
        .R    (R)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic dvd_t ref_q(input int a, input int b);
        if (b == 0) return {(2*N){1'b1}};
        return dvd_t'(a / b);
    endfunction

    function automatic dvs_t ref_r(input int a, input int b);
        if (b == 0) return {N{1'b0}};
        return dvs_t'(a % b);
    endfunction

    // Start one division, scramble the inputs after the start edge, wait for Done.
    task automatic run_div(input int a, input int b, input bit drop);
        int   edges;
        int   busy_cycles;
        dvd_t eq;
        dvs_t er;
        edges       = 0;
        busy_cycles = 0;
        eq = ref_q(a, b);
        er = ref_r(a, b);
        A = dvd_t'(a);
        B = dvs_t'(b);
        s = 1'b1;
        while (!Done && edges < 4 * N + 8) begin
            tick();
            edges++;
            if (Busy) busy_cycles++;
            if (edges == 1) begin
                A = dvd_t'($urandom);
                B = dvs_t'($urandom);
            end
        end
        check("done_seen", 32'(Done), 32'd1);
        check("latency", 32'(edges), (b == 0) ? 32'd1 : 32'(2 * N + 1));
        check("busy_cycles", 32'(busy_cycles), (b == 0) ? 32'd0 : 32'(2 * N));
        check("quotient", 32'(Q), 32'(eq));
        check("remainder", 32'(R), 32'(er));
        check("dz", 32'(DZ), (b == 0) ? 32'd1 : 32'd0);
        if (drop) begin
            s = 1'b0;
            tick();
            check("back_to_idle", 32'(Done), 32'd0);
            check("q_hold_idle", 32'(Q), 32'(eq));
        end
    endtask

    initial begin
        rst = 1'b1;
        s   = 1'b0;
        A   = '0;
        B   = '0;
        tick();
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_dz", 32'(DZ), 32'd0);
        check("rst_q", 32'(Q), 32'd0);
        check("rst_r", 32'(R), 32'd0);
        rst = 1'b0;
        tick();

        run_div(200, 13, 1'b1);
        run_div(255, 1, 1'b1);
        run_div(7, 9, 1'b1);
        run_div(0, 15, 1'b1);
        run_div(100, 0, 1'b1);

        // Hold s through DONE: no restart, results stable.
        run_div(200, 13, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_done", 32'(Done), 32'd1);
            check("hold_busy", 32'(Busy), 32'd0);
            check("hold_q", 32'(Q), 32'd15);
            check("hold_r", 32'(R), 32'd5);
        end
        s = 1'b0;
        tick();
        check("drop_s_idle", 32'(Done), 32'd0);
        check("drop_s_busy", 32'(Busy), 32'd0);
        run_div(50, 7, 1'b1);

        // Asynchronous reset in the middle of an operation.
        A = dvd_t'(200);
        B = dvs_t'(13);
        s = 1'b1;
        tick();
        s = 1'b0;
        tick();
        tick();
        tick();
        check("pre_rst_busy", 32'(Busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async_busy", 32'(Busy), 32'd0);
        check("async_done", 32'(Done), 32'd0);
        check("async_dz", 32'(DZ), 32'd0);
        check("async_q", 32'(Q), 32'd0);
        check("async_r", 32'(R), 32'd0);
        #1 rst = 1'b0;
        tick();
        check("post_rst_idle", 32'(Busy), 32'd0);
        run_div(144, 12, 1'b1);

        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_div(a, b, 1'b1);
            end
        end

        for (int i = 0; i < 200; i++) begin
            run_div(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
